board_column_decoder: RTL and testbench
=======================================

# board_column_decoder

Sequential one-hot-to-index decoder for the eight-queens datapath: accepts a board as N one-hot column words over a valid/ready handshake, decodes each word to its row index, and packs the indices into a solution vector. It is the read-back counterpart of the row-to-column-content encoding stage. It validates one-hotness per column, reports the first bad column, and signals completion with a single-cycle `done` pulse.

## Interface
- `N`, default 8: number of columns and width of each column word; a power of two, 2..16.
- `ROW_W`, default `$clog2(N)` (3): width of one row index.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a board read; sampled only in IDLE.
- `column_content`  in  N  one-hot column word; bit r set means queen in row r.
- `col_valid`  in  1  `column_content` is valid.
- `col_ready`  out  1  block accepts a column this cycle.
- `row_out`  out  ROW_W  decoded row of the most recently accepted column.
- `row_out_valid`  out  1  `row_out` is updated; one-cycle pulse.
- `rows`  out  N*ROW_W  packed solution; column c occupies `[c*ROW_W +: ROW_W]`.
- `error`  out  1  sticky: some column of the current board was not one-hot.
- `err_col`  out  ROW_W  index of the first non-one-hot column; valid when `error` = 1.
- `busy`  out  1  high in COLLECT.
- `done`  out  1  one-cycle pulse when the board is complete.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- **IDLE**
  - `col_ready`=0, `busy`=0.
  - `start`=1 moves to COLLECT, clears `col_idx`, `rows`, `error` and `err_col`.
- **COLLECT**
  - `col_ready`=1, `busy`=1.
  - A transfer occurs when `col_valid`=1 and `col_ready`=1 on a rising edge.
  - On each transfer, the decoded row is written to `rows` slot `col_idx` and to `row_out`; `row_out_valid` is set and `col_idx` increments.
  - A transfer with `col_idx`=N-1 moves the FSM to DONE.
  - `start` is ignored in this state.
- **DONE**
  - `done`=1 and `col_ready`=0 for exactly one cycle, then IDLE.
  - `start` is ignored in DONE; it is honoured from IDLE onwards.
- **Decode rules**
  - Exactly one bit set gives the index of that bit.
  - Zero bits set gives index 0.
  - Multiple bits set gives the index of the lowest set bit.
  - In both the zero and multiple cases `error` is set. `err_col` is loaded with `col_idx` only if `error` was 0 (first fault wins).
- `col_idx` is ROW_W bits wide and never wraps inside a board, because DONE is entered on the N-1 transfer.
- `rows`, `error` and `err_col` hold their values after DONE until the next accepted `start` or `rst`.
- `col_valid` outside COLLECT is ignored. No data is consumed and no state changes.

## Timing
- All outputs are registered.
- Reset values: FSM=IDLE, `col_idx`=0, `col_ready`=0, `busy`=0, `done`=0, `row_out`=0, `row_out_valid`=0, `rows`=0, `error`=0, `err_col`=0.
- `start` sampled at edge 0 gives `col_ready`=`busy`=1 from cycle 1.
- A transfer at edge k gives `row_out`/`row_out_valid` during cycle k+1. The `rows` slot is updated at the same edge.
- Back-to-back transfers are supported, one per cycle, with no bubbles.
- With `col_valid` held high, transfers occur at edges 1..N. `done` is high in cycle N+1, coinciding with the last `row_out_valid` pulse, and `col_ready` is low in that cycle.
- Minimum board period: N+2 cycles from `start` to the next accepted `start`.
- `rst` asserted in any state, including mid-COLLECT, returns the block to reset values at that edge. The partial board is discarded and no `done` is issued.
- `rst` and `start` in the same cycle: `rst` wins.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `start`=1 and `col_valid`=1 → all outputs 0 and FSM in IDLE; `col_ready` stays 0.
- **Valid solution, N=8, streamed:** words 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 sent back-to-back → `row_out` sequence 0,4,7,5,2,6,1,3; `rows`=24'h672BE0; `error`=0; `done` high exactly in cycle 9 after `start`.
- **Faulty columns:** column 3 = 0x00 and column 5 = 0x18, all others valid → `error`=1, `err_col`=3, slot 3 = 0, slot 5 = 3.
- **Backpressure gaps:** drop `col_valid` for 3 cycles after column 2 and for 1 cycle after column 6 → same `rows` as the streamed case; `done` delayed by exactly 4 cycles; no duplicate `row_out_valid` pulses.
- **Reset mid-board:** assert `rst` after 4 transfers → no `done`; `rows`=0; a fresh `start` followed by 8 columns completes correctly.
- **Start ignored outside IDLE:** pulse `start` during COLLECT and in the DONE cycle → `col_idx` is not reset, the board completes normally, and no new board begins until `start` is given in IDLE.

Source files
------------

// File: rtl/board_column_decoder_if.sv
// rtl/board_column_decoder_if.sv - one-hot column word stream into the board column decoder
interface board_column_decoder_if #(
    parameter int N = 8
);
    logic [N-1:0] column_content;
    logic         col_valid;
    logic         col_ready;

    modport master (
        output column_content,
        output col_valid,
        input  col_ready
    );

    modport slave (
        input  column_content,
        input  col_valid,
        output col_ready
    );
endinterface

// File: rtl/board_column_decoder.sv
// rtl/board_column_decoder.sv - decodes N one-hot column words into a packed row-index solution
module board_column_decoder #(
    parameter int N     = 8,
    parameter int ROW_W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    board_column_decoder_if.slave  col,
    output logic [ROW_W-1:0]       row_out,
    output logic                   row_out_valid,
    output logic [N*ROW_W-1:0]     rows,
    output logic                   error,
    output logic [ROW_W-1:0]       err_col,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [ROW_W-1:0] LAST_COL = ROW_W'(N - 1);
    localparam logic [N-1:0]     ONE      = N'(1);

    state_t           state;
    logic [ROW_W-1:0] col_idx;
    logic [ROW_W-1:0] dec_row;
    logic             dec_bad;
    logic             xfer;

    // Scanning downwards leaves the lowest set bit as the final winner.
    function automatic logic [ROW_W-1:0] lowest_set(input logic [N-1:0] w);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w[i]) begin
                idx = ROW_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        dec_row = lowest_set(col.column_content);
        dec_bad = (col.column_content == '0) ||
                  ((col.column_content & (col.column_content - ONE)) != '0);
        xfer    = (state == COLLECT) && col.col_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            col_idx       <= '0;
            col.col_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            row_out       <= '0;
            row_out_valid <= 1'b0;
            rows          <= '0;
            error         <= 1'b0;
            err_col       <= '0;
        end else begin
            row_out_valid <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= COLLECT;
                        col_idx       <= '0;
                        rows          <= '0;
                        error         <= 1'b0;
                        err_col       <= '0;
                        col.col_ready <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        rows[col_idx*ROW_W +: ROW_W] <= dec_row;
                        row_out                      <= dec_row;
                        row_out_valid                <= 1'b1;
                        if (dec_bad) begin
                            error <= 1'b1;
                            if (!error) begin
                                err_col <= col_idx;
                            end
                        end
                        // Last column: ready drops so the DONE cycle accepts nothing.
                        if (col_idx == LAST_COL) begin
                            state         <= DONE;
                            col.col_ready <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_column_decoder.sv
// tb/tb_board_column_decoder.sv - randomized and directed bench for board_column_decoder
module tb_board_column_decoder;
    localparam int N     = 8;
    localparam int ROW_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [ROW_W-1:0]   row_out;
    logic               row_out_valid;
    logic [N*ROW_W-1:0] rows;
    logic               error;
    logic [ROW_W-1:0]   err_col;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] words [N];
    int           gaps  [N];

    always #5 clk = ~clk;

    board_column_decoder_if #(.N(N)) col_if ();

    board_column_decoder #(.N(N), .ROW_W(ROW_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .col           (col_if),
        .row_out       (row_out),
        .row_out_valid (row_out_valid),
        .rows          (rows),
        .error         (error),
        .err_col       (err_col),
        .busy          (busy),
        .done          (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: isolate the lowest set bit arithmetically, then take its log.
    function automatic int ref_row(input logic [N-1:0] w);
        int v;
        v = int'(w);
        if (v == 0) return 0;
        return $clog2(v & -v);
    endfunction

    function automatic bit ref_bad(input logic [N-1:0] w);
        return $countones(w) != 1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, col_if.col_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_row_out"}, row_out, 0);
        check_eq({tag, "_row_out_valid"}, row_out_valid, 0);
        check_eq({tag, "_rows"}, rows, 0);
        check_eq({tag, "_error"}, error, 0);
        check_eq({tag, "_err_col"}, err_col, 0);
    endtask

    task automatic run_board(input string tag, input bit poke_start);
        logic [N*ROW_W-1:0] exp_rows;
        bit                 exp_err;
        int                 exp_ec;
        exp_rows = '0;
        exp_err  = 0;
        exp_ec   = 0;
        for (int c = 0; c < N; c++) begin
            exp_rows[c*ROW_W +: ROW_W] = ROW_W'(ref_row(words[c]));
            if (ref_bad(words[c]) && !exp_err) begin
                exp_err = 1;
                exp_ec  = c;
            end
        end

        start = 1'b1;
        col_if.col_valid = 1'b0;
        step();
        start = 1'b0;
        check_eq({tag, "_busy_start"}, busy, 1);
        check_eq({tag, "_ready_start"}, col_if.col_ready, 1);
        check_eq({tag, "_rows_cleared"}, rows, 0);
        check_eq({tag, "_error_cleared"}, error, 0);

        for (int c = 0; c < N; c++) begin
            col_if.column_content = words[c];
            col_if.col_valid      = 1'b1;
            if (poke_start && c == 3) start = 1'b1;
            step();
            start = 1'b0;
            check_eq({tag, "_row_out_valid"}, row_out_valid, 1);
            check_eq({tag, "_row_out"}, row_out, ref_row(words[c]));
            if (c == N - 1) begin
                check_eq({tag, "_done_last"}, done, 1);
                check_eq({tag, "_ready_in_done"}, col_if.col_ready, 0);
            end else begin
                check_eq({tag, "_done_early"}, done, 0);
                check_eq({tag, "_ready_collect"}, col_if.col_ready, 1);
            end
            col_if.col_valid = 1'b0;
            if (c < N - 1) begin
                for (int g = 0; g < gaps[c]; g++) begin
                    step();
                    check_eq({tag, "_gap_row_out_valid"}, row_out_valid, 0);
                    check_eq({tag, "_gap_done"}, done, 0);
                end
            end
        end

        // Stray valid data and (optionally) a start pulse in the DONE cycle must be ignored.
        col_if.column_content = '1;
        col_if.col_valid      = 1'b1;
        if (poke_start) start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, "_done_once"}, done, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_ready"}, col_if.col_ready, 0);
        check_eq({tag, "_idle_row_out_valid"}, row_out_valid, 0);
        step();
        check_eq({tag, "_still_idle"}, busy, 0);
        check_eq({tag, "_rows"}, rows, exp_rows);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_err_col"}, err_col, exp_ec);
        col_if.col_valid = 1'b0;
    endtask

    task automatic set_valid_solution();
        words = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
        for (int c = 0; c < N; c++) gaps[c] = 0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        col_if.col_valid = 1'b1;
        col_if.column_content = '1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        start = 1'b0;
        col_if.col_valid = 1'b0;
        step();

        set_valid_solution();
        run_board("stream", 0);
        check_eq("stream_rows_const", rows, 24'h672BE0);

        words[3] = 8'h00;
        words[5] = 8'h18;
        run_board("fault", 0);
        check_eq("fault_slot3", rows[3*ROW_W +: ROW_W], 0);
        check_eq("fault_slot5", rows[5*ROW_W +: ROW_W], 3);
        check_eq("fault_err_col", err_col, 3);

        set_valid_solution();
        gaps[2] = 3;
        gaps[6] = 1;
        run_board("backpressure", 0);
        check_eq("backpressure_rows_const", rows, 24'h672BE0);

        set_valid_solution();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            col_if.column_content = words[c];
            col_if.col_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midreset");
        for (int k = 0; k < N + 2; k++) begin
            step();
            check_eq("midreset_no_done", done, 0);
            check_eq("midreset_no_ready", col_if.col_ready, 0);
        end
        check_eq("midreset_rows", rows, 0);
        col_if.col_valid = 1'b0;
        run_board("after_reset", 0);

        set_valid_solution();
        run_board("start_poke", 1);

        for (int b = 0; b < 20; b++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 4) == 0) words[c] = N'($urandom);
                else words[c] = N'(1) << $urandom_range(0, N - 1);
                gaps[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_board("random", b[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
